tone_gen_multi: RTL and testbench

Parametrised successor to the fixed single-square note generator. Produces one audio sample word per sample strobe from a writable half-period table, with selectable waveform (square, 25% pulse, slew-limited square), 3-bit volume and glitch-free note changes. Sits between the note/keyboard decoder and the audio serialiser. The serialiser consumes `word` on each `sample_en`.

---
 rtl/tone_gen_multi_if.sv | 37 +++
 rtl/tone_gen_multi.sv | 132 +++++++++++++
 tb/tb_tone_gen_multi.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tone_gen_multi_if.sv
// ============================================================================
// Module      : tone_gen_multi_if
// Description : Control, table-config and sample-output bundle for tone_gen_multi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tone_gen_multi_if #(
    parameter int WORD_W = 16,
    parameter int DIV_W  = 16,
    parameter int NOTE_W = 3
);
    logic              sample_en;
    logic              note_on;
    logic [NOTE_W-1:0] note_index;
    logic [1:0]        mode;
    logic [2:0]        volume;
    logic              cfg_we;
    logic [NOTE_W-1:0] cfg_addr;
    logic [DIV_W-1:0]  cfg_data;
    logic [WORD_W-1:0] word;
    logic              boundary;

    modport master (
        output sample_en, note_on, note_index, mode, volume,
               cfg_we, cfg_addr, cfg_data,
        input  word, boundary
    );

    modport slave (
        input  sample_en, note_on, note_index, mode, volume,
               cfg_we, cfg_addr, cfg_data,
        output word, boundary
    );
endinterface

`default_nettype wire

// File: rtl/tone_gen_multi.sv
// ============================================================================
// Module      : tone_gen_multi
// Description : Table-driven multi-waveform tone generator, one word per strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_gen_multi #(
    parameter int WORD_W    = 16,
    parameter int AMP_W     = 12,
    parameter int DIV_W     = 16,
    parameter int NOTE_W    = 3,
    parameter int RAMP_STEP = 256
) (
    input  logic           clk,
    input  logic           rst,
    tone_gen_multi_if.slave tg
);
    localparam int               c_DEPTH   = 2 ** NOTE_W;
    localparam logic [AMP_W:0]   c_AMP_MAX = {1'b0, {AMP_W{1'b1}}};
    localparam logic [AMP_W:0]   c_STEP    = (AMP_W + 1)'(RAMP_STEP);
    localparam logic [1:0]       c_SQUARE  = 2'd0;
    localparam logic [1:0]       c_PULSE   = 2'd1;
    localparam logic [1:0]       c_SLEW    = 2'd2;

    // Power-on table: half-period-minus-one for C3..C4 at the sample rate
    function automatic logic [DIV_W-1:0] f_init(input int idx);
        case (idx)
            0:       f_init = DIV_W'(165);
            1:       f_init = DIV_W'(147);
            2:       f_init = DIV_W'(131);
            3:       f_init = DIV_W'(123);
            4:       f_init = DIV_W'(110);
            5:       f_init = DIV_W'(98);
            6:       f_init = DIV_W'(87);
            7:       f_init = DIV_W'(82);
            default: f_init = '0;
        endcase
    endfunction

    logic [DIV_W-1:0]  r_table [c_DEPTH];
    logic [DIV_W-1:0]  r_counter;
    logic [DIV_W-1:0]  r_period;
    logic              r_half;
    logic              r_idle;
    logic [AMP_W-1:0]  r_level;
    logic [WORD_W-1:0] r_word;
    logic              r_boundary;

    logic              w_at_end;
    logic              w_boundary;
    logic [DIV_W-1:0]  w_counter_n;
    logic [DIV_W-1:0]  w_period_n;
    logic              w_half_n;
    logic              w_idle_n;
    logic [AMP_W-1:0]  w_level_n;
    logic [AMP_W:0]    w_up;
    logic [AMP_W-1:0]  w_slew_up;
    logic [AMP_W-1:0]  w_slew_dn;

    assign w_at_end   = (r_counter >= r_period);
    assign w_boundary = tg.sample_en && !r_idle && w_at_end;

    // Saturating slew arithmetic done one bit wider so the climb never wraps
    assign w_up      = {1'b0, r_level} + c_STEP;
    assign w_slew_up = (w_up > c_AMP_MAX) ? c_AMP_MAX[AMP_W-1:0] : w_up[AMP_W-1:0];
    assign w_slew_dn = ({1'b0, r_level} < c_STEP) ? '0 : (r_level - c_STEP[AMP_W-1:0]);

    always_comb begin
        w_counter_n = r_counter;
        w_period_n  = r_period;
        w_half_n    = r_half;
        w_idle_n    = r_idle;
        if (!tg.note_on) begin
            w_idle_n    = 1'b1;
            w_counter_n = '0;
            w_half_n    = 1'b0;
        end else if (r_idle) begin
            w_idle_n   = 1'b0;
            w_period_n = r_table[tg.note_index];
        end else if (w_at_end) begin
            // New note index is only honoured here, so a half is never cut short
            w_period_n  = r_table[tg.note_index];
            w_counter_n = '0;
            w_half_n    = ~r_half;
        end else begin
            w_counter_n = r_counter + 1'b1;
        end

        w_level_n = '0;
        case (tg.mode)
            c_SQUARE: w_level_n = w_half_n ? c_AMP_MAX[AMP_W-1:0] : '0;
            c_PULSE:  w_level_n = (w_half_n && (w_counter_n <= (w_period_n >> 1)))
                                  ? c_AMP_MAX[AMP_W-1:0] : '0;
            c_SLEW:   w_level_n = w_half_n ? w_slew_up : w_slew_dn;
            default:  w_level_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_table[i] <= f_init(i);
            end
            r_counter  <= '0;
            r_period   <= '0;
            r_half     <= 1'b0;
            r_idle     <= 1'b1;
            r_level    <= '0;
            r_word     <= '0;
            r_boundary <= 1'b0;
        end else begin
            if (tg.cfg_we) begin
                r_table[tg.cfg_addr] <= tg.cfg_data;
            end
            r_boundary <= w_boundary;
            if (tg.sample_en) begin
                r_counter <= w_counter_n;
                r_period  <= w_period_n;
                r_half    <= w_half_n;
                r_idle    <= w_idle_n;
                r_level   <= w_level_n;
                r_word    <= WORD_W'(w_level_n >> (3'd7 - tg.volume));
            end
        end
    end

    assign tg.word     = r_word;
    assign tg.boundary = r_boundary;
endmodule

`default_nettype wire

// File: tb/tb_tone_gen_multi.sv
// ============================================================================
// Module      : tb_tone_gen_multi
// Description : Directed self-checking bench for tone_gen_multi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_gen_multi;
    localparam logic [15:0] c_FULL = 16'h0FFF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    tone_gen_multi_if #(.WORD_W(16), .DIV_W(16), .NOTE_W(3)) tg ();

    tone_gen_multi #(
        .WORD_W(16), .AMP_W(12), .DIV_W(16), .NOTE_W(3), .RAMP_STEP(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tg  (tg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic strobe();
        @(negedge clk);
        tg.sample_en = 1'b1;
        @(negedge clk);
        tg.sample_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        tg.sample_en  = 1'b0;
        tg.note_on    = 1'b0;
        tg.note_index = '0;
        tg.mode       = 2'd0;
        tg.volume     = 3'd7;
        tg.cfg_we     = 1'b0;
        tg.cfg_addr   = '0;
        tg.cfg_data   = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        tg.cfg_we   = 1'b1;
        tg.cfg_addr = addr;
        tg.cfg_data = data;
        @(negedge clk);
        tg.cfg_we   = 1'b0;
    endtask

    // Square wave starting low: first half p1 strobes, later halves p2 strobes
    function automatic logic [15:0] sq_exp(input int k, input int p1, input int p2);
        if (k <= p1) return 16'h0;
        return (((k - p1 - 1) / p2) % 2 == 0) ? c_FULL : 16'h0;
    endfunction

    function automatic logic bnd_exp(input int k, input int p1, input int p2);
        return (k > p1) && ((k - p1 - 1) % p2 == 0);
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;

        // Reset state
        do_reset();
        check("reset_word", 32'(tg.word), 32'h0);
        check("reset_bnd", 32'(tg.boundary), 32'h0);

        // Plain square on entry 0: 166-strobe halves
        tg.note_on = 1'b1;
        for (int k = 1; k <= 340; k++) begin
            strobe();
            check($sformatf("sq_word[%0d]", k), 32'(tg.word), 32'(sq_exp(k, 166, 166)));
            check($sformatf("sq_bnd[%0d]", k), 32'(tg.boundary), 32'(bnd_exp(k, 166, 166)));
        end

        // Note change mid-half waits for the boundary
        do_reset();
        tg.note_on = 1'b1;
        for (int k = 1; k <= 340; k++) begin
            if (k == 50) tg.note_index = 3'd7;
            strobe();
            check($sformatf("sw_word[%0d]", k), 32'(tg.word), 32'(sq_exp(k, 166, 83)));
            check($sformatf("sw_bnd[%0d]", k), 32'(tg.boundary), 32'(bnd_exp(k, 166, 83)));
        end

        // Pulse25 with a short written entry: high only for counter 0..4
        do_reset();
        cfg_write(3'd2, 16'd9);
        tg.note_index = 3'd2;
        tg.mode       = 2'd1;
        tg.note_on    = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            strobe();
            check($sformatf("pl_word[%0d]", k), 32'(tg.word),
                  ((k > 10) && (((k - 11) % 20) < 5)) ? 32'h0FFF : 32'h0);
            check($sformatf("pl_bnd[%0d]", k), 32'(tg.boundary), 32'(bnd_exp(k, 10, 10)));
        end

        // Slew: saturating climb to 0x0FFF and descent to 0
        do_reset();
        tg.mode    = 2'd2;
        tg.note_on = 1'b1;
        for (int k = 1; k <= 360; k++) begin
            int e;
            if (k <= 166)      e = 0;
            else if (k <= 332) e = (256 * (k - 166) > 4095) ? 4095 : 256 * (k - 166);
            else               e = (4095 - 256 * (k - 332) < 0) ? 0 : 4095 - 256 * (k - 332);
            strobe();
            check($sformatf("sl_word[%0d]", k), 32'(tg.word), 32'(e));
        end

        // Volume 4, then note off and restart from counter 0
        do_reset();
        tg.volume  = 3'd4;
        tg.note_on = 1'b1;
        for (int k = 1; k <= 167; k++) strobe();
        check("vol_high", 32'(tg.word), 32'h01FF);
        tg.note_on = 1'b0;
        strobe();
        check("off_word", 32'(tg.word), 32'h0);
        tg.note_on = 1'b1;
        for (int k = 1; k <= 166; k++) strobe();
        check("restart_low", 32'(tg.word), 32'h0);
        strobe();
        check("restart_high", 32'(tg.word), 32'h01FF);
        check("restart_bnd", 32'(tg.boundary), 32'h1);

        // Table write applies at the next latch; reset restores the table
        do_reset();
        tg.note_on = 1'b1;
        for (int k = 1; k <= 100; k++) strobe();
        cfg_write(3'd0, 16'd3);
        for (int k = 101; k <= 166; k++) strobe();
        check("wr_keep_low", 32'(tg.word), 32'h0);
        strobe();
        check("wr_bnd167", 32'(tg.boundary), 32'h1);
        check("wr_high167", 32'(tg.word), 32'h0FFF);
        for (int k = 168; k <= 170; k++) strobe();
        check("wr_high170", 32'(tg.word), 32'h0FFF);
        strobe();
        check("wr_low171", 32'(tg.word), 32'h0);
        check("wr_bnd171", 32'(tg.boundary), 32'h1);
        for (int k = 172; k <= 175; k++) strobe();
        check("wr_high175", 32'(tg.word), 32'h0FFF);
        do_reset();
        check("rst_mid_word", 32'(tg.word), 32'h0);
        check("rst_mid_bnd", 32'(tg.boundary), 32'h0);
        tg.note_on = 1'b1;
        for (int k = 1; k <= 166; k++) strobe();
        check("rst_tbl_low", 32'(tg.word), 32'h0);
        strobe();
        check("rst_tbl_high", 32'(tg.word), 32'h0FFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
